life_pattern_loader: RTL and testbench

//   Drives the write port of the life cell array (row/col/val/write_enb). It

---
 rtl/life_pattern_loader_if.sv | 21 ++
 rtl/life_pattern_loader.sv | 94 +++++++++
 tb/tb_life_pattern_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/life_pattern_loader_if.sv
// life_pattern_loader_if: seed-load handshake and cell-array write port of the life pattern loader.
interface life_pattern_loader_if;
    logic        start_i;
    logic [15:0] pattern_i;
    logic        frame_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  row_o;
    logic [1:0]  col_o;
    logic        val_o;
    logic        write_enb_o;
    logic        run_inhibit_o;
    modport slave (
        input  start_i, pattern_i, frame_i,
        output busy_o, done_o, row_o, col_o, val_o, write_enb_o, run_inhibit_o
    );
    modport master (
        output start_i, pattern_i, frame_i,
        input  busy_o, done_o, row_o, col_o, val_o, write_enb_o, run_inhibit_o
    );
endinterface

// File: rtl/life_pattern_loader.sv
// life_pattern_loader: writes a 16-bit seed into the life cell array, one cell per write strobe.
module life_pattern_loader #(
    parameter int GAP_CYCLES = 0,
    parameter bit SYNC_FRAME = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    life_pattern_loader_if.slave lp
);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, SYNC, WRITE, GAP, DONE} state_t;
    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [GW-1:0] cnt_q, cnt_d;
    logic [15:0]   pat_q, pat_d;
    logic          busy_q, busy_d, done_q, done_d, val_q, val_d, we_q, we_d, inh_q, inh_d;
    logic [1:0]    row_q, row_d, col_q, col_d;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            val_q   <= 1'b0;
            we_q    <= 1'b0;
            inh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            row_q   <= row_d;
            col_q   <= col_d;
            val_q   <= val_d;
            we_q    <= we_d;
            inh_q   <= inh_d;
        end
    end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        case (state_q)
            IDLE: if (lp.start_i) begin
                pat_d   = lp.pattern_i;
                idx_d   = '0;
                cnt_d   = '0;
                state_d = SYNC_FRAME ? SYNC : WRITE;
            end
            SYNC: state_d = lp.frame_i ? WRITE : SYNC;
            WRITE: begin
                if (idx_q == 4'd15) state_d = DONE;
                else if (GAP_CYCLES == 0) idx_d = idx_q + 4'd1;
                else begin
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == GW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 4'd1;
                    state_d = WRITE;
                end else cnt_d = cnt_q + GW'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Outputs are decoded from the next state so the registered copies line up with that state.
    always_comb begin
        we_d   = state_d == WRITE;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
        inh_d  = state_d inside {WRITE, GAP, DONE};
        row_d  = we_d ? idx_d[3:2] : 2'd0;
        col_d  = we_d ? idx_d[1:0] : 2'd0;
        val_d  = we_d & pat_d[idx_d];
    end
    assign lp.busy_o        = busy_q;
    assign lp.done_o        = done_q;
    assign lp.row_o         = row_q;
    assign lp.col_o         = col_q;
    assign lp.val_o         = val_q;
    assign lp.write_enb_o   = we_q;
    assign lp.run_inhibit_o = inh_q;
endmodule

// File: tb/tb_life_pattern_loader.sv
// tb_life_pattern_loader: directed tests of the loader in three configurations plus an array/run model.
module tb_life_pattern_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    life_pattern_loader_if if0 ();
    life_pattern_loader_if if1 ();
    life_pattern_loader_if if2 ();
    life_pattern_loader #(.GAP_CYCLES(0), .SYNC_FRAME(1'b0)) u0 (.clk(clk), .reset(reset), .lp(if0.slave));
    life_pattern_loader #(.GAP_CYCLES(2), .SYNC_FRAME(1'b0)) u1 (.clk(clk), .reset(reset), .lp(if1.slave));
    life_pattern_loader #(.GAP_CYCLES(0), .SYNC_FRAME(1'b1)) u2 (.clk(clk), .reset(reset), .lp(if2.slave));
    int passed = 0;
    int total = 0;
    logic [8:0] o0, o1, o2;
    assign o0 = {if0.busy_o, if0.done_o, if0.row_o, if0.col_o, if0.val_o, if0.write_enb_o, if0.run_inhibit_o};
    assign o1 = {if1.busy_o, if1.done_o, if1.row_o, if1.col_o, if1.val_o, if1.write_enb_o, if1.run_inhibit_o};
    assign o2 = {if2.busy_o, if2.done_o, if2.row_o, if2.col_o, if2.val_o, if2.write_enb_o, if2.run_inhibit_o};
    // Expected {busy,done,row,col,val,write_enb,run_inhibit} in cycle c after the launching edge.
    function automatic logic [8:0] exp_out(input int c, input int gap, input logic [15:0] p);
        int per, last, idx;
        logic we;
        logic [3:0] i4;
        per  = gap + 1;
        last = 1 + 15 * per;
        we   = c >= 1 && c <= last && ((c - 1) % per == 0);
        idx  = (c - 1) / per;
        i4   = we ? 4'(idx) : 4'd0;
        return {c >= 1 && c <= last + 1, c == last + 1, i4, we ? p[i4] : 1'b0, we, c >= 1 && c <= last + 1};
    endfunction
    function automatic logic [15:0] life_step(input logic [15:0] a);
        logic [15:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 4 && c + dc >= 0 && c + dc < 4)
                            cnt += int'(a[(r + dr) * 4 + c + dc]);
                n[r * 4 + c] = a[r * 4 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        return n;
    endfunction
    // Cell array fed by u2; a run step competes with writes, so a missing inhibit corrupts the load.
    logic [15:0] alive = '0;
    logic model_init = 1'b0;
    always @(posedge clk) begin
        if (model_init) alive <= 16'hFFFF;
        else if (if2.frame_i && !if2.run_inhibit_o) alive <= life_step(alive);
        else if (if2.write_enb_o) alive[{if2.row_o, if2.col_o}] <= if2.val_o;
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic accept0(input logic [15:0] p);
        tick;
        if0.start_i = 1'b1;
        if0.pattern_i = p;
        tick;
        if0.start_i = 1'b0;
    endtask
    task automatic accept1(input logic [15:0] p);
        tick;
        if1.start_i = 1'b1;
        if1.pattern_i = p;
        tick;
        if1.start_i = 1'b0;
    endtask
    task automatic accept2(input logic [15:0] p);
        tick;
        if2.start_i = 1'b1;
        if2.pattern_i = p;
        tick;
        if2.start_i = 1'b0;
    endtask
    task automatic test_reset;
        #3 reset = 1'b0;
        #1;
        total += 3;
        if (o0 !== 9'd0) $display("FAIL reset u0: got %b want %b", o0, 9'd0); else passed++;
        if (o1 !== 9'd0) $display("FAIL reset u1: got %b want %b", o1, 9'd0); else passed++;
        if (o2 !== 9'd0) $display("FAIL reset u2: got %b want %b", o2, 9'd0); else passed++;
        @(negedge clk) reset = 1'b1;
    endtask
    task automatic test_back_to_back;
        logic [8:0] e;
        accept0(16'hA5C3);
        if0.pattern_i = 16'h0000;
        for (int c = 1; c <= 18; c++) begin
            e = exp_out(c, 0, 16'hA5C3);
            total++;
            if (o0 !== e) $display("FAIL back_to_back cycle %0d: got %b want %b", c, o0, e); else passed++;
            tick;
        end
    endtask
    task automatic test_gap;
        logic [8:0] e;
        accept1(16'hFFFF);
        for (int c = 1; c <= 48; c++) begin
            e = exp_out(c, 2, 16'hFFFF);
            total++;
            if (o1 !== e) $display("FAIL gap cycle %0d: got %b want %b", c, o1, e); else passed++;
            tick;
        end
    endtask
    task automatic test_sync;
        logic [8:0] e;
        accept2(16'h3C5A);
        for (int c = 1; c <= 100; c++) begin
            total++;
            if (o2 !== 9'b1_0000_0000) $display("FAIL sync_wait cycle %0d: got %b want %b", c, o2, 9'b1_0000_0000); else passed++;
            if2.frame_i = c == 100;
            tick;
        end
        for (int c = 1; c <= 18; c++) begin
            e = exp_out(c, 0, 16'h3C5A);
            total++;
            if (o2 !== e) $display("FAIL sync_load cycle %0d: got %b want %b", c, o2, e); else passed++;
            if2.frame_i = c == 3 || c == 10;
            tick;
        end
        if2.frame_i = 1'b0;
    endtask
    task automatic test_start_ignored;
        logic [8:0] e;
        accept0(16'h1234);
        for (int c = 1; c <= 36; c++) begin
            e = c <= 18 ? exp_out(c, 0, 16'h1234) : exp_out(c - 18, 0, 16'h00F0);
            total++;
            if (o0 !== e) $display("FAIL start_ignored cycle %0d: got %b want %b", c, o0, e); else passed++;
            if0.start_i = c == 5 || c == 17 || c == 18;
            if0.pattern_i = c == 18 ? 16'h00F0 : 16'hFFFF;
            tick;
        end
        if0.start_i = 1'b0;
    endtask
    task automatic test_reset_mid_load;
        logic [8:0] e;
        logic [15:0] seen;
        int writes;
        accept0(16'hFFFF);
        for (int c = 1; c <= 7; c++) tick;
        #2 reset = 1'b0;
        #1;
        total++;
        if (o0 !== 9'd0) $display("FAIL async_reset: got %b want %b", o0, 9'd0); else passed++;
        @(negedge clk) reset = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick;
            total++;
            if (o0 !== 9'd0) $display("FAIL post_reset_idle cycle %0d: got %b want %b", c, o0, 9'd0); else passed++;
        end
        seen = '0;
        writes = 0;
        accept0(16'h5AA5);
        for (int c = 1; c <= 18; c++) begin
            e = exp_out(c, 0, 16'h5AA5);
            total++;
            if (o0 !== e) $display("FAIL reload cycle %0d: got %b want %b", c, o0, e); else passed++;
            if (if0.write_enb_o === 1'b1) begin
                seen[{if0.row_o, if0.col_o}] = if0.val_o;
                writes++;
            end
            tick;
        end
        total += 2;
        if (writes !== 16) $display("FAIL reload_writes: got %0d want 16", writes); else passed++;
        if (seen !== 16'h5AA5) $display("FAIL reload_cells: got %h want 5aa5", seen); else passed++;
    endtask
    task automatic test_run_gating;
        model_init = 1'b1;
        tick;
        model_init = 1'b0;
        total++;
        if (alive !== 16'hFFFF) $display("FAIL model_init: got %h want ffff", alive); else passed++;
        accept2(16'h0660);
        for (int c = 1; c <= 5; c++) tick;
        if2.frame_i = 1'b1;
        tick;
        if2.frame_i = 1'b0;
        total++;
        if (alive !== 16'h9009) $display("FAIL sync_step_ungated: got %h want 9009", alive); else passed++;
        for (int c = 1; c <= 18; c++) begin
            if (c == 9) begin
                total++;
                if (alive !== 16'h9060) $display("FAIL half_loaded: got %h want 9060", alive); else passed++;
            end
            if2.frame_i = c % 4 == 2;
            tick;
        end
        if2.frame_i = 1'b0;
        total++;
        if (alive !== 16'h0660) $display("FAIL loaded_block: got %h want 0660", alive); else passed++;
        total++;
        if (if2.run_inhibit_o !== 1'b0) $display("FAIL inhibit_released: got %b want 0", if2.run_inhibit_o); else passed++;
        if2.frame_i = 1'b1;
        tick;
        if2.frame_i = 1'b0;
        total++;
        if (alive !== 16'h0660) $display("FAIL block_still_life: got %h want 0660", alive); else passed++;
    endtask
    initial begin
        if0.start_i = 1'b0; if0.pattern_i = '0; if0.frame_i = 1'b0;
        if1.start_i = 1'b0; if1.pattern_i = '0; if1.frame_i = 1'b0;
        if2.start_i = 1'b0; if2.pattern_i = '0; if2.frame_i = 1'b0;
        test_reset;
        test_back_to_back;
        test_gap;
        test_sync;
        test_start_ignored;
        test_reset_mid_load;
        test_run_gating;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
